// File: rtl/jts16_exp_pkg.sv
// Shared definitions for the i8243-compatible PCM expander.
// Opcodes and port indices come from the MCU's P2[3:0] nibble at the PROG falling edge.
package jts16_exp_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned PSEL_W = 2;
    localparam int unsigned NPORT  = 4;

    localparam logic [OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] OP_OR    = 2'b10;
    localparam logic [OP_W-1:0] OP_AND   = 2'b11;

    localparam logic [PSEL_W-1:0] PORT_P4 = 2'd0;
    localparam logic [PSEL_W-1:0] PORT_P5 = 2'd1;
    localparam logic [PSEL_W-1:0] PORT_P6 = 2'd2;
    localparam logic [PSEL_W-1:0] PORT_P7 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RDRV = 2'd2
    } state_t;

endpackage

// File: rtl/jts16_exp_port.sv
// One 4-bit expander port: output register plus output-enable.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   apply_c     one-clock strobe: apply op/data to the register, set oe
//   op          WRITE / OR / AND (READ leaves the register alone)
//   data        nibble from MCU P2
//   rd_c        one-clock strobe: port turns into an input (oe cleared)
//   o, oe       registered port output and output-enable
module jts16_exp_port
    import jts16_exp_pkg::*;
#(
    parameter logic [NIB_W-1:0] PORT_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             apply_c,
    input  logic [OP_W-1:0]  op,
    input  logic [NIB_W-1:0] data,
    input  logic             rd_c,
    output logic [NIB_W-1:0] o,
    output logic             oe
);

    logic [NIB_W-1:0] nxt_o_c;

    // OR/AND act on the output register, never on the pin value
    always_comb begin
        nxt_o_c = o;
        case (op)
            OP_WRITE: nxt_o_c = data;
            OP_OR:    nxt_o_c = o | data;
            OP_AND:   nxt_o_c = o & data;
            default:  nxt_o_c = o;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o  <= PORT_RST;
            oe <= 1'b0;
        end else if (apply_c) begin
            o  <= nxt_o_c;
            oe <= 1'b1;
        end else if (rd_c) begin
            oe <= 1'b0;
        end
    end

endmodule

// File: rtl/jts16_pcm_exp.sv
// i8243-compatible I/O expander (responder side of the T48 PROG/P2 bus).
// PROG falling edge carries opcode/port on P2, rising edge carries data.
// Build option: JTS16_EXP_RDBACK_EN enables READ (port drives back onto P2);
// without it READ is a no-op, p2_oe=0 and p2_o=4'hF.
// Ports:
//   clk, rst_n, cen   clock, async active-low reset, 6 MHz clock enable
//   cs_n, prog_n      chip select (sampled at PROG fall), PROG strobe
//   p2_i / p2_o/p2_oe MCU nibble in, read-back nibble out + its enable
//   pN_i/pN_o/pN_oe   expander ports P4..P7
module jts16_pcm_exp
    import jts16_exp_pkg::*;
#(
    parameter logic [NIB_W-1:0] PORT_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             cs_n,
    input  logic             prog_n,
    input  logic [NIB_W-1:0] p2_i,
    output logic [NIB_W-1:0] p2_o,
    output logic             p2_oe,
    input  logic [NIB_W-1:0] p4_i,
    input  logic [NIB_W-1:0] p5_i,
    input  logic [NIB_W-1:0] p6_i,
    input  logic [NIB_W-1:0] p7_i,
    output logic [NIB_W-1:0] p4_o,
    output logic [NIB_W-1:0] p5_o,
    output logic [NIB_W-1:0] p6_o,
    output logic [NIB_W-1:0] p7_o,
    output logic             p4_oe,
    output logic             p5_oe,
    output logic             p6_oe,
    output logic             p7_oe
);

    state_t            state, nxt_state;
    logic [OP_W-1:0]   op_q, nxt_op;
    logic [PSEL_W-1:0] port_q, nxt_port;
    logic              prog_l;
    logic              fall_c, rise_c;
    logic [NPORT-1:0]  apply_c, rd_c;
    logic [NIB_W-1:0]  port_o  [NPORT];
    logic [NPORT-1:0]  port_oe;

    // PROG edges only exist as seen on cen; glitches between enables vanish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   prog_l <= 1'b1;
        else if (cen) prog_l <= prog_n;
    end

    assign fall_c = cen & ~prog_n &  prog_l;
    assign rise_c = cen &  prog_n & ~prog_l;

    // State and latched opcode/port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= OP_READ;
            port_q <= PORT_P4;
        end else begin
            state  <= nxt_state;
            op_q   <= nxt_op;
            port_q <= nxt_port;
        end
    end

    // Next state and port strobes; cs_n only matters at the falling edge
    always_comb begin
        nxt_state = state;
        nxt_op    = op_q;
        nxt_port  = port_q;
        apply_c   = '0;
        rd_c      = '0;
        case (state)
            IDLE: begin
                if (fall_c && !cs_n) begin
                    nxt_op    = p2_i[3:2];
                    nxt_port  = p2_i[1:0];
                    nxt_state = XFER;
`ifdef JTS16_EXP_RDBACK_EN
                    if (p2_i[3:2] == OP_READ) begin
                        nxt_state        = RDRV;
                        rd_c[p2_i[1:0]]  = 1'b1;
                    end
`endif
                end
            end
            XFER: begin
                if (rise_c) begin
                    nxt_state = IDLE;
                    if (op_q != OP_READ) apply_c[port_q] = 1'b1;
                end
            end
            RDRV: begin
                if (rise_c) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        jts16_exp_port #(.PORT_RST(PORT_RST)) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .apply_c (apply_c[i]),
            .op      (op_q),
            .data    (p2_i),
            .rd_c    (rd_c[i]),
            .o       (port_o[i]),
            .oe      (port_oe[i])
        );
    end

    assign p4_o  = port_o[PORT_P4];
    assign p5_o  = port_o[PORT_P5];
    assign p6_o  = port_o[PORT_P6];
    assign p7_o  = port_o[PORT_P7];
    assign p4_oe = port_oe[PORT_P4];
    assign p5_oe = port_oe[PORT_P5];
    assign p6_oe = port_oe[PORT_P6];
    assign p7_oe = port_oe[PORT_P7];

`ifdef JTS16_EXP_RDBACK_EN
    logic [NIB_W-1:0] pin_c [NPORT];

    assign pin_c[PORT_P4] = p4_i;
    assign pin_c[PORT_P5] = p5_i;
    assign pin_c[PORT_P6] = p6_i;
    assign pin_c[PORT_P7] = p7_i;

    // Read-back driver: enabled at the READ fall, pin refreshed every cen until rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_oe <= 1'b0;
            p2_o  <= '0;
        end else if (cen) begin
            if (state == IDLE && nxt_state == RDRV) begin
                p2_oe <= 1'b1;
                p2_o  <= pin_c[p2_i[1:0]];
            end else if (state == RDRV) begin
                if (rise_c) p2_oe <= 1'b0;
                else        p2_o  <= pin_c[port_q];
            end
        end
    end
`else
    assign p2_oe = 1'b0;
    assign p2_o  = 4'hF;

    logic unused_pins;
    assign unused_pins = &{1'b0, p4_i, p5_i, p6_i, p7_i};
`endif

endmodule

// File: tb/tb_jts16_pcm_exp.sv
// Directed self-checking bench for jts16_pcm_exp (default PORT_RST=0).
module tb_jts16_pcm_exp;

    logic       clk = 1'b0;
    logic       rst_n, cen, cs_n, prog_n;
    logic [3:0] p2_i, p2_o;
    logic       p2_oe;
    logic [3:0] p4_i, p5_i, p6_i, p7_i;
    logic [3:0] p4_o, p5_o, p6_o, p7_o;
    logic       p4_oe, p5_oe, p6_oe, p7_oe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jts16_pcm_exp dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .prog_n(prog_n),
        .p2_i(p2_i), .p2_o(p2_o), .p2_oe(p2_oe),
        .p4_i(p4_i), .p5_i(p5_i), .p6_i(p6_i), .p7_i(p7_i),
        .p4_o(p4_o), .p5_o(p5_o), .p6_o(p6_o), .p7_o(p7_o),
        .p4_oe(p4_oe), .p5_oe(p5_oe), .p6_oe(p6_oe), .p7_oe(p7_oe)
    );

    // One cen cycle; returns at the negedge after the enabled posedge
    task automatic cen_pulse();
        @(negedge clk); cen = 1'b1;
        @(negedge clk); cen = 1'b0;
    endtask

    task automatic prog_fall(input logic [3:0] code, input logic sel_n);
        @(negedge clk);
        prog_n = 1'b0; p2_i = code; cs_n = sel_n;
        cen_pulse();
    endtask

    task automatic prog_rise(input logic [3:0] data);
        @(negedge clk);
        prog_n = 1'b1; p2_i = data;
        cen_pulse();
    endtask

    task automatic test_reset();
        logic [19:0] o_all;
        logic [3:0]  oe_all;
        rst_n = 1'b0; cen = 1'b0; cs_n = 1'b1; prog_n = 1'b1; p2_i = 4'h0;
        p4_i = 4'h1; p5_i = 4'h2; p6_i = 4'h7; p7_i = 4'h0;
        repeat (3) @(negedge clk);
        o_all  = {p4_o, p5_o, p6_o, p7_o, p2_oe, 3'b000};
        oe_all = {p4_oe, p5_oe, p6_oe, p7_oe};
        checks++;
        if (o_all !== 20'h00000) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", o_all, 20'h00000);
        end
        checks++;
        if (oe_all !== 4'b0000) begin
            failures++; $display("FAIL reset_oe got=%b exp=%b", oe_all, 4'b0000);
        end
        rst_n = 1'b1;
        repeat (20) cen_pulse();
        o_all  = {p4_o, p5_o, p6_o, p7_o, p2_oe, 3'b000};
        oe_all = {p4_oe, p5_oe, p6_oe, p7_oe};
        checks++;
        if (o_all !== 20'h00000 || oe_all !== 4'b0000) begin
            failures++; $display("FAIL idle_hold got=%h/%b exp=00000/0000", o_all, oe_all);
        end
`ifndef JTS16_EXP_RDBACK_EN
        checks++;
        if (p2_o !== 4'hF) begin
            failures++; $display("FAIL p2_o_tied got=%h exp=f", p2_o);
        end
`endif
    endtask

    task automatic test_write();
        prog_fall(4'b0101, 1'b0);
        @(negedge clk); prog_n = 1'b1; p2_i = 4'hA; cen = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (p5_o !== 4'hA || p5_oe !== 1'b1) begin
            failures++; $display("FAIL write_latency got=%h/%b exp=a/1", p5_o, p5_oe);
        end
        @(negedge clk); cen = 1'b0;
        checks++;
        if ({p4_o, p6_o, p7_o, p4_oe, p6_oe, p7_oe} !== 15'h0) begin
            failures++; $display("FAIL write_others got=%h exp=0",
                                 {p4_o, p6_o, p7_o, p4_oe, p6_oe, p7_oe});
        end
    endtask

    task automatic test_or_and();
        prog_fall(4'b0110, 1'b0); prog_rise(4'hC);
        checks++;
        if (p6_o !== 4'hC || p6_oe !== 1'b1) begin
            failures++; $display("FAIL p6_write got=%h/%b exp=c/1", p6_o, p6_oe);
        end
        prog_fall(4'b1010, 1'b0); prog_rise(4'h3);
        checks++;
        if (p6_o !== 4'hF) begin
            failures++; $display("FAIL p6_or got=%h exp=f", p6_o);
        end
        prog_fall(4'b1110, 1'b0); prog_rise(4'h5);
        checks++;
        if (p6_o !== 4'h5) begin
            failures++; $display("FAIL p6_and got=%h exp=5", p6_o);
        end
        checks++;
        if ({p4_o, p5_o, p7_o} !== 12'h0A0 || {p4_oe, p5_oe, p7_oe} !== 3'b010) begin
            failures++; $display("FAIL or_and_others got=%h/%b exp=0a0/010",
                                 {p4_o, p5_o, p7_o}, {p4_oe, p5_oe, p7_oe});
        end
    endtask

    task automatic test_read();
        prog_fall(4'b0111, 1'b0); prog_rise(4'h6);
        p7_i = 4'h9;
        prog_fall(4'b0011, 1'b0);
`ifdef JTS16_EXP_RDBACK_EN
        checks++;
        if (p7_oe !== 1'b0 || p7_o !== 4'h6 || p2_oe !== 1'b1 || p2_o !== 4'h9) begin
            failures++; $display("FAIL read_start got=%b/%h/%b/%h exp=0/6/1/9",
                                 p7_oe, p7_o, p2_oe, p2_o);
        end
        p7_i = 4'h2;
        cen_pulse();
        checks++;
        if (p2_o !== 4'h2 || p2_oe !== 1'b1) begin
            failures++; $display("FAIL read_refresh got=%h/%b exp=2/1", p2_o, p2_oe);
        end
        prog_rise(4'h0);
        checks++;
        if (p2_oe !== 1'b0 || p7_o !== 4'h6) begin
            failures++; $display("FAIL read_end got=%b/%h exp=0/6", p2_oe, p7_o);
        end
`else
        checks++;
        if (p2_oe !== 1'b0 || p2_o !== 4'hF) begin
            failures++; $display("FAIL read_nop_p2 got=%b/%h exp=0/f", p2_oe, p2_o);
        end
        prog_rise(4'h0);
        checks++;
        if (p7_oe !== 1'b1 || p7_o !== 4'h6 || p2_oe !== 1'b0) begin
            failures++; $display("FAIL read_nop_port got=%b/%h/%b exp=1/6/0", p7_oe, p7_o, p2_oe);
        end
`endif
    endtask

    task automatic test_cs_and_glitch();
        prog_fall(4'b0100, 1'b1);
        cs_n = 1'b0;
        prog_rise(4'h3);
        checks++;
        if (p4_o !== 4'h0 || p4_oe !== 1'b0) begin
            failures++; $display("FAIL cs_ignored got=%h/%b exp=0/0", p4_o, p4_oe);
        end
        // PROG pulse entirely between enables
        @(negedge clk); prog_n = 1'b0; p2_i = 4'b0100;
        @(negedge clk); prog_n = 1'b1; p2_i = 4'hE;
        cen_pulse(); cen_pulse();
        checks++;
        if (p4_o !== 4'h0 || p4_oe !== 1'b0) begin
            failures++; $display("FAIL glitch_ignored got=%h/%b exp=0/0", p4_o, p4_oe);
        end
        prog_fall(4'b0100, 1'b0); prog_rise(4'h3);
        checks++;
        if (p4_o !== 4'h3 || p4_oe !== 1'b1) begin
            failures++; $display("FAIL idle_after_cs got=%h/%b exp=3/1", p4_o, p4_oe);
        end
    endtask

    task automatic test_reset_mid();
        prog_fall(4'b0100, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        checks++;
        if (p4_o !== 4'h0 || p4_oe !== 1'b0 || p6_o !== 4'h0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%h exp=0/0/0", p4_o, p4_oe, p6_o);
        end
        prog_n = 1'b1; p2_i = 4'hC;
        @(negedge clk); rst_n = 1'b1;
        cen_pulse(); cen_pulse();
        checks++;
        if (p4_o !== 4'h0 || p4_oe !== 1'b0) begin
            failures++; $display("FAIL abort_no_write got=%h/%b exp=0/0", p4_o, p4_oe);
        end
        prog_fall(4'b0100, 1'b0); prog_rise(4'h9);
        checks++;
        if (p4_o !== 4'h9 || p4_oe !== 1'b1) begin
            failures++; $display("FAIL post_reset_write got=%h/%b exp=9/1", p4_o, p4_oe);
        end
`ifdef JTS16_EXP_RDBACK_EN
        p5_i = 4'h4;
        prog_fall(4'b0001, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        checks++;
        if (p2_oe !== 1'b0) begin
            failures++; $display("FAIL read_reset_p2oe got=%b exp=0", p2_oe);
        end
        prog_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_or_and();
        test_read();
        test_cs_and_glitch();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
